// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain: WIDTH-bit payload plus valid per stage,
// with a global stall (hold) and a per-stage flush (kill) for hazard handling.
module pipe_reg_chain #(
    parameter int               WIDTH     = 64,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic [STAGES-1:0]               flush,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    output logic [STAGES-1:0]               stage_valid,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipe_reg_chain: STAGES must be at least 1");
        end
    endgenerate

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];

    // A stalled stage holds unless flagged; an advancing stage takes its
    // predecessor unless that predecessor was flagged. Reset overrides both.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= RESET_VAL;
            end
        end else if (stall) begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k]) begin
                    v[k] <= 1'b0;
                    d[k] <= RESET_VAL;
                end
            end
        end else begin
            v[0] <= in_valid;
            d[0] <= in_data;
            for (int k = 1; k < STAGES; k++) begin
                if (flush[k-1]) begin
                    v[k] <= 1'b0;
                    d[k] <= RESET_VAL;
                end else begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
        end
    end

    assign out_valid   = v[STAGES-1];
    assign out_data    = d[STAGES-1];
    assign stage_valid = v;

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(v[k]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed scenarios plus a randomized run against a
// kill-then-advance list model, on a 3-stage and a 1-stage instance.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [2:0]  stage_valid;
    logic [1:0]  occupancy;

    logic        stall1;
    logic [0:0]  flush1;
    logic        in_valid1;
    logic [15:0] in_data1;
    logic        out_valid1;
    logic [15:0] out_data1;
    logic [0:0]  stage_valid1;
    logic [0:0]  occupancy1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference: each pipe is a list of (valid, data) entries.
    logic        m_v  [3];
    logic [63:0] m_d  [3];
    logic        m1_v;
    logic [15:0] m1_d;

    pipe_reg_chain #(.WIDTH(64), .STAGES(3), .RESET_VAL(64'h0)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .stage_valid(stage_valid), .occupancy(occupancy)
    );

    pipe_reg_chain #(.WIDTH(16), .STAGES(1), .RESET_VAL(16'hDEAD)) dut_b (
        .clk(clk), .reset(reset), .stall(stall1), .flush(flush1),
        .in_valid(in_valid1), .in_data(in_data1),
        .out_valid(out_valid1), .out_data(out_data1),
        .stage_valid(stage_valid1), .occupancy(occupancy1)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        if (reset) begin
            for (int k = 0; k < 3; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
            m1_v = 1'b0; m1_d = 16'hDEAD;
        end else begin
            // Killed entries turn into bubbles, then the list advances by one.
            for (int k = 0; k < 3; k++)
                if (flush[k]) begin m_v[k] = 1'b0; m_d[k] = '0; end
            if (!stall) begin
                for (int k = 2; k > 0; k--) begin m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; end
                m_v[0] = in_valid; m_d[0] = in_data;
            end
            if (flush1[0]) begin m1_v = 1'b0; m1_d = 16'hDEAD; end
            if (!stall1) begin m1_v = in_valid1; m1_d = in_data1; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; flush = '0; in_valid = 1'b0; in_data = '0;
        stall1 = 1'b0; flush1 = '0; in_valid1 = 1'b0; in_data1 = '0;
    endtask

    task automatic push(input logic [63:0] val);
        in_valid = 1'b1; in_data = val;
        tick();
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total_cnt++;
        if ({out_valid, out_data, stage_valid, occupancy} !== {1'b0, 64'h0, 3'b000, 2'd0})
            $display("FAIL reset_a: got v=%0b d=%h sv=%b occ=%0d, want 0/0/000/0",
                     out_valid, out_data, stage_valid, occupancy);
        else pass_cnt++;
        total_cnt++;
        if ({out_valid1, out_data1, occupancy1} !== {1'b0, 16'hDEAD, 1'b0})
            $display("FAIL reset_b: got v=%0b d=%h occ=%0d, want 0/dead/0",
                     out_valid1, out_data1, occupancy1);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [63:0] vals [3];
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            push(vals[i]);
            total_cnt++;
            if (occupancy !== 2'(i + 1))
                $display("FAIL fill_occ%0d: got %0d want %0d", i, occupancy, i + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if ({out_valid, out_data, stage_valid} !== {1'b1, 64'h11, 3'b111})
            $display("FAIL fill_out: got v=%0b d=%h sv=%b want 1/11/111",
                     out_valid, out_data, stage_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [63:0] expect_seq [3];
        expect_seq[0] = 64'h22; expect_seq[1] = 64'h33; expect_seq[2] = 64'h44;
        stall = 1'b1; in_valid = 1'b1; in_data = 64'h44;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if ({out_valid, out_data, stage_valid, occupancy} !== {1'b1, 64'h11, 3'b111, 2'd3})
                $display("FAIL stall_hold%0d: got v=%0b d=%h sv=%b occ=%0d want 1/11/111/3",
                         i, out_valid, out_data, stage_valid, occupancy);
            else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({out_valid, out_data} !== {1'b1, expect_seq[i]})
                $display("FAIL stall_drain%0d: got v=%0b d=%h want 1/%h",
                         i, out_valid, out_data, expect_seq[i]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_flush_stage0();
        test_reset();
        push(64'h11);
        flush = 3'b001; in_valid = 1'b1; in_data = 64'h22;
        tick();
        flush = '0; in_valid = 1'b0; in_data = '0;
        total_cnt++;
        if ({stage_valid, occupancy} !== {3'b001, 2'd1})
            $display("FAIL flush0_sv: got sv=%b occ=%0d want 001/1", stage_valid, occupancy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, out_data} !== {1'b0, 64'h0})
            $display("FAIL flush0_slot: got v=%0b d=%h want 0/0", out_valid, out_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, out_data} !== {1'b1, 64'h22})
            $display("FAIL flush0_next: got v=%0b d=%h want 1/22", out_valid, out_data);
        else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        test_reset();
        push(64'h11); push(64'h22); push(64'h33);
        stall = 1'b1; flush = 3'b010; in_valid = 1'b1; in_data = 64'h99;
        tick();
        flush = '0;
        total_cnt++;
        if ({out_valid, out_data, stage_valid, occupancy} !== {1'b1, 64'h11, 3'b101, 2'd2})
            $display("FAIL stallflush: got v=%0b d=%h sv=%b occ=%0d want 1/11/101/2",
                     out_valid, out_data, stage_valid, occupancy);
        else pass_cnt++;
        stall = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        total_cnt++;
        if ({out_valid, out_data} !== {1'b0, 64'h0})
            $display("FAIL stallflush_bubble: got v=%0b d=%h want 0/0", out_valid, out_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, out_data} !== {1'b1, 64'h33})
            $display("FAIL stallflush_keep: got v=%0b d=%h want 1/33", out_valid, out_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        push(64'hA1); push(64'hA2); push(64'hA3);
        stall = 1'b1; flush = 3'b111; reset = 1'b1; in_valid = 1'b1; in_data = 64'h55;
        tick();
        idle_inputs();
        total_cnt++;
        if ({out_valid, out_data, stage_valid, occupancy} !== {1'b0, 64'h0, 3'b000, 2'd0})
            $display("FAIL reset_mid: got v=%0b d=%h sv=%b occ=%0d want 0/0/000/0",
                     out_valid, out_data, stage_valid, occupancy);
        else pass_cnt++;
    endtask

    task automatic test_single_stage();
        in_valid1 = 1'b1; in_data1 = 16'h0005;
        tick();
        in_valid1 = 1'b0; in_data1 = 16'h1234;
        total_cnt++;
        if ({out_valid1, out_data1, occupancy1} !== {1'b1, 16'h0005, 1'b1})
            $display("FAIL single_load: got v=%0b d=%h occ=%0d want 1/0005/1",
                     out_valid1, out_data1, occupancy1);
        else pass_cnt++;
        stall1 = 1'b1;
        tick();
        total_cnt++;
        if ({out_valid1, out_data1} !== {1'b1, 16'h0005})
            $display("FAIL single_hold: got v=%0b d=%h want 1/0005", out_valid1, out_data1);
        else pass_cnt++;
        flush1 = 1'b1;
        tick();
        stall1 = 1'b0; flush1 = '0;
        total_cnt++;
        if ({out_valid1, out_data1, occupancy1} !== {1'b0, 16'hDEAD, 1'b0})
            $display("FAIL single_kill: got v=%0b d=%h occ=%0d want 0/dead/0",
                     out_valid1, out_data1, occupancy1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0] exp_sv;
        logic [1:0] exp_occ;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            in_valid  = 1'($urandom);
            in_data   = {$urandom, $urandom};
            stall1    = ($urandom_range(0, 3) == 0);
            flush1    = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            in_valid1 = 1'($urandom);
            in_data1  = 16'($urandom);
            tick();
            exp_sv  = {m_v[2], m_v[1], m_v[0]};
            exp_occ = 2'(m_v[0]) + 2'(m_v[1]) + 2'(m_v[2]);
            total_cnt++;
            if ({out_valid, out_data, stage_valid, occupancy} !== {m_v[2], m_d[2], exp_sv, exp_occ})
                $display("FAIL rand_a%0d: got v=%0b d=%h sv=%b occ=%0d want %0b/%h/%b/%0d",
                         n, out_valid, out_data, stage_valid, occupancy,
                         m_v[2], m_d[2], exp_sv, exp_occ);
            else pass_cnt++;
            total_cnt++;
            if ({out_valid1, out_data1, stage_valid1, occupancy1} !== {m1_v, m1_d, m1_v, m1_v})
                $display("FAIL rand_b%0d: got v=%0b d=%h occ=%0d want %0b/%h/%0d",
                         n, out_valid1, out_data1, occupancy1, m1_v, m1_d, m1_v);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_fill();
        test_stall();
        test_flush_stage0();
        test_stall_flush();
        test_reset_mid();
        test_single_stage();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
